// File: rtl/fft_frame_buffer.sv
// Serial-to-parallel frame assembler in front of the FFT.
// Fills one frame, then hands it to a single output register.
module fft_frame_buffer #(
   parameter int sample_size = 32,
   parameter int buffer_size = 32
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic signed [sample_size-1:0]             sample_in,
   input  logic                                      sample_valid,
   output logic                                      sample_ready,
   input  logic                                      flush,
   output logic signed [buffer_size*sample_size-1:0] frame_out,
   output logic                                      frame_valid,
   input  logic                                      frame_ready,
   output logic [$clog2(buffer_size+1)-1:0]          fill_level
);

   localparam int lw = $clog2(buffer_size+1);
   localparam int fw = buffer_size*sample_size;

   typedef enum logic {
      fill_s,
      full_s
   } state_t;

   state_t          state;
   state_t          state_d;
   logic [lw-1:0]   level_d;
   logic [fw-1:0]   fill_q;
   logic [fw-1:0]   frame_d;
   logic            accept;
   logic            slot_free;
   logic            last;
   logic            load;
   logic            valid_d;

   assign sample_ready = (state == fill_s) && !flush && rst_n;
   assign accept       = sample_valid && sample_ready;
   assign slot_free    = !frame_valid || frame_ready;
   assign last         = accept && (fill_level == lw'(buffer_size-1));

   // Direct load bypasses the top slot with the incoming sample
   assign frame_d = (state == full_s) ? fill_q :
                    {sample_in, fill_q[fw-sample_size-1:0]};

   always_comb begin
      state_d = state;
      level_d = fill_level;
      load    = 1'b0;
      unique case (state)
         fill_s: begin
            if (flush) begin
               level_d = '0;
            end else if (last) begin
               if (slot_free) begin
                  load    = 1'b1;
                  level_d = '0;
               end else begin
                  state_d = full_s;
                  level_d = lw'(buffer_size);
               end
            end else if (accept) begin
               level_d = fill_level + 1'b1;
            end
         end
         full_s: begin
            if (flush) begin
               state_d = fill_s;
               level_d = '0;
            end else if (slot_free) begin
               load    = 1'b1;
               state_d = fill_s;
               level_d = '0;
            end
         end
         default: begin
            state_d = fill_s;
            level_d = '0;
         end
      endcase
      if (load) begin
         valid_d = 1'b1;
      end else if (frame_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = frame_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= fill_s;
         fill_level  <= '0;
         frame_valid <= 1'b0;
         frame_out   <= '0;
      end else begin
         state       <= state_d;
         fill_level  <= level_d;
         frame_valid <= valid_d;
         if (load) begin
            frame_out <= frame_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else begin
         for (int i = 0; i < buffer_size; i++) begin
            if (accept && (fill_level == lw'(i))) begin
               fill_q[i*sample_size +: sample_size] <= sample_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: queue-based frame model checked
// every cycle, plus directed literal checks.
module tb_fft_frame_buffer;

   localparam int sw = 32;
   localparam int n  = 32;
   localparam int fw = n*sw;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [sw-1:0] sample_in = '0;
   logic                 sample_valid = 1'b0;
   logic                 sample_ready;
   logic                 flush = 1'b0;
   logic signed [fw-1:0] frame_out;
   logic                 frame_valid;
   logic                 frame_ready = 1'b0;
   logic [5:0]           fill_level;

   int checks = 0;
   int errors = 0;

   fft_frame_buffer #(.sample_size(sw), .buffer_size(n)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample_in(sample_in),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .flush(flush),
      .frame_out(frame_out),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   // behavioural model: partial frame as a queue, one pending flag
   logic [sw-1:0] part[$];
   bit            pend = 0;
   logic [fw-1:0] mfo = '0;
   bit            mfv = 0;
   int            frames = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chkf(input string nm, input logic [fw-1:0] got,
                       input logic [fw-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         for (int k = 0; k < n; k++) begin
            if (got[k*sw +: sw] !== exp[k*sw +: sw]) begin
               $display("FAIL %s slice %0d got %0h exp %0h at %0t", nm, k,
                        got[k*sw +: sw], exp[k*sw +: sw], $time);
               break;
            end
         end
      end
   endtask

   function automatic logic [fw-1:0] pack_part();
      logic [fw-1:0] f = '0;
      for (int k = 0; k < n; k++) f[k*sw +: sw] = part[k];
      return f;
   endfunction

   always @(negedge rst_n) begin
      part.delete();
      pend = 0;
      mfo  = '0;
      mfv  = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         bit free;
         bit ld;
         free = !mfv || frame_ready;
         ld   = 0;
         if (flush) begin
            part.delete();
            pend = 0;
         end else if (pend) begin
            ld = free;
         end else if (sample_valid) begin
            part.push_back(sample_in);
            if (part.size() == n) begin
               if (free) ld = 1;
               else pend = 1;
            end
         end
         if (ld) begin
            mfo = pack_part();
            part.delete();
            pend = 0;
            mfv  = 1;
            frames++;
         end else if (mfv && frame_ready) begin
            mfv = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("sample_ready", 64'(sample_ready),
          64'(!pend && !flush && rst_n));
      chk("fill_level", 64'(fill_level), 64'(part.size()));
      chk("frame_valid", 64'(frame_valid), 64'(mfv));
      chkf("frame_out", frame_out, mfo);
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [sw-1:0] v);
      int  cnt = 0;
      logic a;
      sample_in    = v;
      sample_valid = 1'b1;
      do begin
         #1;
         a = sample_ready;
         @(negedge clk);
         #1;
         cnt++;
      end while (!a && cnt < 200);
      if (!a) begin
         errors++;
         $display("FAIL send_timeout value %0h", v);
      end
      sample_valid = 1'b0;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_frame_valid", 64'(frame_valid), 64'd0);
      chk("rst_fill_level", 64'(fill_level), 64'd0);
      chk("rst_sample_ready", 64'(sample_ready), 64'd0);
      chk("rst_frame_out_lo", frame_out[63:0], 64'd0);
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      int start;
      int budget;
      repeat (3) cyc();
      chk("reset_ready_low", 64'(sample_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_release", 64'(sample_ready), 64'd1);

      // 1..32 straight through
      frame_ready = 1'b1;
      for (int k = 0; k < n; k++) send(sw'(k + 1));
      frame_ready = 1'b0;
      chk("t1_valid", 64'(frame_valid), 64'd1);
      chk("t1_level", 64'(fill_level), 64'd0);
      chk("t1_slice0", 64'(frame_out[0 +: sw]), 64'd1);
      chk("t1_slice31", 64'(frame_out[31*sw +: sw]), 64'd32);

      // stalled consumer: second frame waits in FULL
      for (int k = 0; k < n; k++) send(sw'(k + 33));
      chk("t2_level_full", 64'(fill_level), 64'd32);
      chk("t2_ready_low", 64'(sample_ready), 64'd0);
      chk("t2_held_slice0", 64'(frame_out[0 +: sw]), 64'd1);
      frame_ready = 1'b1;
      cyc();
      frame_ready = 1'b0;
      chk("t2_no_gap", 64'(frame_valid), 64'd1);
      chk("t2_second_slice0", 64'(frame_out[0 +: sw]), 64'd33);
      chk("t2_second_slice31", 64'(frame_out[31*sw +: sw]), 64'd64);

      // flush mid-frame with a sample offered
      frame_ready = 1'b1;
      for (int k = 0; k < 10; k++) send(sw'(200 + k));
      flush        = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 32'd999;
      cyc();
      flush        = 1'b0;
      sample_valid = 1'b0;
      chk("t3_level_flushed", 64'(fill_level), 64'd0);
      for (int k = 0; k < n; k++) send(sw'(100 + k));
      chk("t3_slice0", 64'(frame_out[0 +: sw]), 64'd100);
      chk("t3_slice31", 64'(frame_out[31*sw +: sw]), 64'd131);

      // sign extremes
      for (int k = 0; k < n; k++)
         send((k % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
      frame_ready = 1'b0;
      chk("t4_neg", 64'(frame_out[0 +: sw]), 64'h8000_0000);
      chk("t4_pos", 64'(frame_out[1*sw +: sw]), 64'h7FFF_FFFF);
      chk("t4_neg_hi", 64'(frame_out[30*sw +: sw]), 64'h8000_0000);

      // async reset mid-frame and in FULL
      for (int k = 0; k < 20; k++) send(sw'(k + 300));
      async_reset();
      for (int k = 0; k < 2*n; k++) send(sw'(k + 400));
      chk("t5_full_level", 64'(fill_level), 64'd32);
      async_reset();
      frame_ready = 1'b1;
      for (int k = 0; k < n; k++) send(sw'(k + 500));
      chk("t5_clean_slice0", 64'(frame_out[0 +: sw]), 64'd500);
      chk("t5_clean_slice31", 64'(frame_out[31*sw +: sw]), 64'd531);

      // random stalls and rare flushes
      start  = frames;
      budget = 0;
      while (frames < start + 1000 && budget < 80000) begin
         sample_valid = ($urandom % 10) < 8;
         sample_in    = $urandom;
         frame_ready  = ($urandom % 10) < 7;
         flush        = ($urandom % 500) == 0;
         cyc();
         budget++;
      end
      sample_valid = 1'b0;
      flush        = 1'b0;
      chk("random_frames_done", 64'(frames >= start + 1000), 64'd1);
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
